// File: rtl/ram_march_controller_if.sv
// Port bundle of the March C- BIST sequencer: control, RAM port and result readout.
// The sequencer uses the master view; the RAM skeleton and readout logic use the slave view.
interface ram_march_controller_if #(
    parameter int BITWIDTH_DATA = 12,
    parameter int BITWIDTH_ADR  = 6,
    parameter int BITWIDTH_ERR  = 16
);
    logic                     EN;
    logic                     START;
    logic                     RAM_EN;
    logic                     RAM_WE;
    logic [BITWIDTH_ADR-1:0]  RAM_ADR;
    logic [BITWIDTH_DATA-1:0] RAM_DIN;
    logic [BITWIDTH_DATA-1:0] RAM_DOUT;
    logic                     BUSY;
    logic                     DONE;
    logic                     PASS;
    logic [BITWIDTH_ERR-1:0]  ERR_CNT;
    logic [BITWIDTH_ADR-1:0]  FIRST_ERR_ADR;
    logic [2:0]               ELEM;

    modport master (
        input  EN, START, RAM_DOUT,
        output RAM_EN, RAM_WE, RAM_ADR, RAM_DIN,
               BUSY, DONE, PASS, ERR_CNT, FIRST_ERR_ADR, ELEM
    );

    modport slave (
        output EN, START, RAM_DOUT,
        input  RAM_EN, RAM_WE, RAM_ADR, RAM_DIN,
               BUSY, DONE, PASS, ERR_CNT, FIRST_ERR_ADR, ELEM
    );
endinterface

// File: rtl/ram_march_controller.sv
// March C- self-test sequencer for a single-port RAM with one-cycle read latency.
// Runs M0..M5 over addresses 0..NUM_POSITIONS-1 and reports pass, error count and first failing address.
module ram_march_controller #(
    parameter int BITWIDTH_DATA = 12,
    parameter int BITWIDTH_ADR  = 6,
    parameter int NUM_POSITIONS = 2**BITWIDTH_ADR - 4,
    parameter int BITWIDTH_ERR  = 16
) (
    input  logic                   CLK_SYS,
    input  logic                   RST,
    ram_march_controller_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RW, S_CHK, S_FIN} state_t;

    localparam logic [BITWIDTH_ADR-1:0] LAST_ADR = BITWIDTH_ADR'(NUM_POSITIONS - 1);

    state_t                   state_q, state_d;
    logic [BITWIDTH_ADR-1:0]  adr_q, adr_d;
    logic [2:0]               elem_q, elem_d;
    logic [BITWIDTH_ERR-1:0]  err_q, err_d;
    logic [BITWIDTH_ADR-1:0]  fea_q, fea_d;
    logic                     seen_q, seen_d;
    logic                     pass_q, pass_d;

    logic                     ram_en, ram_we, busy, done;
    logic [BITWIDTH_DATA-1:0] ram_din;

    logic                     descending, at_last, mismatch;
    logic [BITWIDTH_ADR-1:0]  step_adr, next_start;
    logic [2:0]               next_elem;
    logic [BITWIDTH_DATA-1:0] rd_bg, wr_bg;

    // M3/M4 walk downwards; every other element walks upwards.
    assign descending = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign at_last    = descending ? (adr_q == '0) : (adr_q == LAST_ADR);
    assign step_adr   = descending ? adr_q - BITWIDTH_ADR'(1) : adr_q + BITWIDTH_ADR'(1);
    assign next_elem  = elem_q + 3'd1;
    assign next_start = ((next_elem == 3'd3) || (next_elem == 3'd4)) ? LAST_ADR : '0;

    // Reads expect O in M2/M4 and Z elsewhere; RW writes O in M1/M3 and Z in M2/M4.
    assign rd_bg = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
    assign wr_bg = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? '1 : '0;

    // RAM_DOUT belongs to the read issued in the preceding RD cycle.
    assign mismatch = ((state_q == S_RW) || (state_q == S_CHK)) && (bus.RAM_DOUT != rd_bg);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d = state_q;
        adr_d   = adr_q;
        elem_d  = elem_q;
        err_d   = err_q;
        fea_d   = fea_q;
        seen_d  = seen_q;
        pass_d  = pass_q;
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        ram_din = '0;
        busy    = 1'b0;
        done    = 1'b0;

        if (mismatch) begin
            if (err_q != '1) err_d = err_q + BITWIDTH_ERR'(1);
            if (!seen_q) begin
                seen_d = 1'b1;
                fea_d  = adr_q;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    state_d = S_WR;
                    adr_d   = '0;
                    elem_d  = '0;
                    err_d   = '0;
                    fea_d   = '0;
                    seen_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_WR: begin
                busy = 1'b1;
                if (bus.EN) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                    if (at_last) begin
                        elem_d  = next_elem;
                        adr_d   = next_start;
                        state_d = S_RD;
                    end else begin
                        adr_d = step_adr;
                    end
                end
            end
            S_RD: begin
                busy = 1'b1;
                if (bus.EN) begin
                    ram_en  = 1'b1;
                    state_d = (elem_q == 3'd5) ? S_CHK : S_RW;
                end
            end
            S_RW: begin
                busy    = 1'b1;
                ram_en  = 1'b1;
                ram_we  = 1'b1;
                ram_din = wr_bg;
                state_d = S_RD;
                if (at_last) begin
                    elem_d = next_elem;
                    adr_d  = next_start;
                end else begin
                    adr_d = step_adr;
                end
            end
            S_CHK: begin
                busy = 1'b1;
                if (at_last) begin
                    state_d = S_FIN;
                    // Resolved here, including this cycle's compare, so PASS is valid alongside DONE.
                    pass_d  = (err_d == '0);
                end else begin
                    adr_d   = step_adr;
                    state_d = S_RD;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_SYS or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            elem_q  <= '0;
            err_q   <= '0;
            fea_q   <= '0;
            seen_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q <= state_d;
            adr_q   <= adr_d;
            elem_q  <= elem_d;
            err_q   <= err_d;
            fea_q   <= fea_d;
            seen_q  <= seen_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.RAM_EN        = ram_en;
    assign bus.RAM_WE        = ram_we;
    assign bus.RAM_ADR       = adr_q;
    assign bus.RAM_DIN       = ram_din;
    assign bus.BUSY          = busy;
    assign bus.DONE          = done;
    assign bus.PASS          = pass_q;
    assign bus.ERR_CNT       = err_q;
    assign bus.FIRST_ERR_ADR = fea_q;
    assign bus.ELEM          = elem_q;
endmodule

// File: tb/tb_ram_march_controller.sv
// Bench for ram_march_controller: behavioural RAM with injectable faults, a queue of expected
// RAM accesses built from the March C- order, and a table of full runs plus reset/retrigger cases.
module tb_ram_march_controller;
    localparam int BD = 12;
    localparam int BA = 6;
    localparam int BE = 4;
    localparam int N  = 60;

    logic CLK_SYS = 1'b0;
    logic RST     = 1'b1;
    always #5 CLK_SYS = ~CLK_SYS;

    ram_march_controller_if #(.BITWIDTH_DATA(BD), .BITWIDTH_ADR(BA), .BITWIDTH_ERR(BE)) bus ();

    ram_march_controller #(
        .BITWIDTH_DATA(BD), .BITWIDTH_ADR(BA), .NUM_POSITIONS(N), .BITWIDTH_ERR(BE)
    ) dut (
        .CLK_SYS(CLK_SYS),
        .RST    (RST),
        .bus    (bus)
    );

    typedef struct {
        logic          we;
        logic [BA-1:0] adr;
        logic [BD-1:0] din;
        logic [2:0]    elem;
    } acc_t;

    typedef struct {
        int fault;   // 0 ideal, 1 bit3 stuck-at-1 at adr 17, 2 bit0 stuck-at-0 everywhere
        bit stall;
        int pass;
        int err;
        int fea;
        int len;
    } vec_t;

    acc_t exp_q[$];
    vec_t vecs[4];
    int   checks = 0;
    int   errors = 0;
    int   fault_mode = 0;

    logic [BD-1:0] mem [0:(1<<BA)-1];

    function automatic logic [BD-1:0] read_fault(input logic [BD-1:0] d, input logic [BA-1:0] a,
                                                 input int mode);
        logic [BD-1:0] r;
        r = d;
        if (mode == 1 && a == BA'(17)) r[3] = 1'b1;
        else if (mode == 2) r[0] = 1'b0;
        return r;
    endfunction

    always @(posedge CLK_SYS) begin
        if (bus.RAM_EN) begin
            if (bus.RAM_WE) mem[bus.RAM_ADR] <= bus.RAM_DIN;
            else bus.RAM_DOUT <= read_fault(mem[bus.RAM_ADR], bus.RAM_ADR, fault_mode);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic build_expected();
        int a;
        logic [BD-1:0] bg;
        exp_q.delete();
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                a  = (e == 3 || e == 4) ? N - 1 - k : k;
                bg = (e == 1 || e == 3) ? {BD{1'b1}} : '0;
                if (e > 0) exp_q.push_back('{1'b0, BA'(a), '0, 3'(e)});
                if (e < 5) exp_q.push_back('{1'b1, BA'(a), bg, 3'(e)});
            end
        end
    endtask

    task automatic monitor_access();
        acc_t x;
        if (bus.RAM_EN) begin
            check("access_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                check("acc_we", bus.RAM_WE, x.we);
                check("acc_adr", bus.RAM_ADR, x.adr);
                check("acc_elem", bus.ELEM, x.elem);
                if (x.we) check("acc_din", bus.RAM_DIN, x.din);
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".ram_en"}, bus.RAM_EN, 0);
        check({tag, ".ram_we"}, bus.RAM_WE, 0);
        check({tag, ".ram_adr"}, bus.RAM_ADR, 0);
        check({tag, ".ram_din"}, bus.RAM_DIN, 0);
        check({tag, ".busy"}, bus.BUSY, 0);
        check({tag, ".done"}, bus.DONE, 0);
        check({tag, ".pass"}, bus.PASS, 0);
        check({tag, ".err_cnt"}, bus.ERR_CNT, 0);
        check({tag, ".first_err_adr"}, bus.FIRST_ERR_ADR, 0);
        check({tag, ".elem"}, bus.ELEM, 0);
    endtask

    // Offsets are counted from the first M0 write; both windows open on an RD cycle of M3.
    function automatic bit in_stall(input int o);
        return (o >= 320 && o <= 324) || (o >= 405 && o <= 409);
    endfunction

    task automatic run_vec(input vec_t v);
        bit done_seen;
        fault_mode = v.fault;
        build_expected();
        bus.EN = 1'b1;
        @(negedge CLK_SYS) bus.START = 1'b1;
        @(negedge CLK_SYS) bus.START = 1'b0;
        done_seen = 1'b0;
        for (int c = 1; c <= 900 && !done_seen; c++) begin
            if (c > 1) @(negedge CLK_SYS);
            bus.EN = !(v.stall && in_stall(c - 1));
            #1;
            if (c == 1) begin
                check("start.busy", bus.BUSY, 1);
                check("start.err_cleared", bus.ERR_CNT, 0);
                check("start.pass_cleared", bus.PASS, 0);
            end
            monitor_access();
            if (bus.DONE) begin
                done_seen = 1'b1;
                check("run_len", c - 1, v.len);
                check("done.busy", bus.BUSY, 0);
                check("done.pass", bus.PASS, v.pass);
                check("done.err_cnt", bus.ERR_CNT, v.err);
                check("done.first_err_adr", bus.FIRST_ERR_ADR, v.fea);
            end else begin
                check("run.busy", bus.BUSY, 1);
            end
        end
        check("done_seen", done_seen, 1);
        check("queue_drained", exp_q.size(), 0);
        bus.EN = 1'b1;
        @(negedge CLK_SYS);
        #1;
        check("after.done_pulse", bus.DONE, 0);
        check("after.pass_held", bus.PASS, v.pass);
        check("after.err_held", bus.ERR_CNT, v.err);
        if (v.fault == 0) begin
            for (int a = 0; a < N; a++) check("ram_final_zero", mem[a], 0);
        end
    endtask

    initial begin
        vecs[0] = '{0, 1'b0, 1, 0,  0,  660};
        vecs[1] = '{1, 1'b0, 0, 3,  17, 660};
        vecs[2] = '{2, 1'b0, 0, 15, 0,  660};
        vecs[3] = '{0, 1'b1, 1, 0,  0,  670};

        bus.EN    = 1'b0;
        bus.START = 1'b0;
        repeat (2) @(negedge CLK_SYS);
        #1;
        check_zero_outputs("in_reset");
        RST = 1'b0;
        @(negedge CLK_SYS);
        #1;
        check_zero_outputs("post_reset");

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Retrigger while busy, then abort with reset in the middle of M2.
        fault_mode = 0;
        build_expected();
        bus.EN = 1'b1;
        @(negedge CLK_SYS) bus.START = 1'b1;
        @(negedge CLK_SYS) bus.START = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) @(negedge CLK_SYS);
            bus.START = (c == 50);
            #1;
            check("retrig.busy", bus.BUSY, 1);
            monitor_access();
        end
        bus.START = 1'b0;
        check("abort_in_m2", bus.ELEM, 2);
        RST = 1'b1;
        #1;
        check_zero_outputs("abort_reset");
        @(negedge CLK_SYS);
        RST = 1'b0;
        repeat (3) @(negedge CLK_SYS);
        #1;
        check_zero_outputs("abort_idle");

        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_march_controller.md
# ram_march_controller

Built-in self-test sequencer for the single-port block RAM under test in the RAM skeleton. On a start trigger it owns the RAM port, runs a six-element March C- sequence over every addressable position, and compares each read against the expected background. It reports pass/fail, a saturating error count and the first failing address to the skeleton's readout logic.

## Interface
- BITWIDTH_DATA, 12: RAM word width.
- BITWIDTH_ADR, 6: RAM address width.
- NUM_POSITIONS, 2**BITWIDTH_ADR-4: number of tested positions, addresses 0..NUM_POSITIONS-1. Must be ≥2.
- BITWIDTH_ERR, 16: width of the error counter.

Ports:
- CLK_SYS  in  1  system clock, all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  run enable. When 0, the sequencer stalls at the next step boundary.
- START  in  1  single-cycle trigger, honoured only in IDLE.
- RAM_EN  out  1  RAM port enable.
- RAM_WE  out  1  RAM write enable (1 = write).
- RAM_ADR  out  BITWIDTH_ADR  RAM address.
- RAM_DIN  out  BITWIDTH_DATA  RAM write data.
- RAM_DOUT  in  BITWIDTH_DATA  RAM read data. Valid one cycle after a read-enabled cycle.
- BUSY  out  1  high while a test runs.
- DONE  out  1  one-cycle pulse at test end.
- PASS  out  1  result of the last test, held until the next START.
- ERR_CNT  out  BITWIDTH_ERR  number of mismatching reads, saturating.
- FIRST_ERR_ADR  out  BITWIDTH_ADR  address of the first mismatch.
- ELEM  out  3  current march element (0..5).

## Operation
- Backgrounds: Z = all zeros, O = all ones, both BITWIDTH_DATA wide.
- Elements:
  - M0: ascending, write Z.
  - M1: ascending, read Z then write O.
  - M2: ascending, read O then write Z.
  - M3: descending, read Z then write O.
  - M4: descending, read O then write Z.
  - M5: ascending, read Z.
- Ascending order runs 0→NUM_POSITIONS-1. Descending order runs NUM_POSITIONS-1→0.
- The address counter never leaves this range; non-power-of-two ranges terminate at the last valid index, with no wrap.
- FSM states:
  - IDLE:
    - START=1 clears ERR_CNT, FIRST_ERR_ADR, PASS and the first-error flag.
    - Then go to WR, with element 0 and address 0.
  - WR: single write step (M0 only).
  - RD: issue a read of the current address (EN=1, WE=0).
  - RW: write for M1–M4. Also the compare cycle for the read issued in RD.
  - CHK: M5 compare cycle. RAM_EN=0.
  - FIN: DONE=1 for one cycle, PASS = (ERR_CNT==0), then return to IDLE.
- Step completion:
  - After the last address of an element, advance ELEM and load the start address of the next element.
  - After M5's last CHK, go to FIN.
- Compare:
  - A mismatch occurs when RAM_DOUT ≠ expected background.
  - Each mismatch increments ERR_CNT, which saturates at all-ones.
  - The first mismatch captures RAM_ADR of the read into FIRST_ERR_ADR.
- Stall:
  - EN is sampled only before entering WR or RD.
  - If EN=0, hold state and address with RAM_EN=0. BUSY stays 1.
  - An issued RD always completes its RW/CHK cycle regardless of EN.
- START while BUSY is ignored. START and EN are independent: START with EN=0 enters the run stalled.
- RAM_EN=0 in IDLE, CHK, FIN and in stalls. RAM_WE=1 only in WR and RW.

## Timing
- Reset value: every output is 0, including RAM_ADR, RAM_DIN and ELEM. State is IDLE.
- Reset asserted mid-test aborts immediately: all outputs return to reset values and RAM contents are undefined.
- START sampled high in cycle t: BUSY=1 from t+1, and the first M0 write is issued in t+1.
- Cycles per element: M0 takes 1 per address; M1–M5 take 2 per address.
- Total run with no stalls is 11·NUM_POSITIONS cycles. FIN follows, so DONE goes high at t+1+11·N and BUSY drops in that same cycle.
- PASS, ERR_CNT and FIRST_ERR_ADR are final and stable when DONE=1.
- Compare latency: RAM_DOUT is registered into the compare in the cycle directly after RD, i.e. one-cycle RAM read latency.
- Each stall cycle extends the total by exactly 1.

## Test plan
- Ideal RAM model, N=60, EN=1, START pulse → DONE exactly 660 cycles after the first WR cycle. PASS=1, ERR_CNT=0. RAM ends all zeros.
- RAM model with bit 3 stuck-at-1 at address 17 → PASS=0, FIRST_ERR_ADR=17, ERR_CNT=3. The mismatches are the Z reads in M1, M3 and M5.
- Stuck-at-0 on bit 0 of every address with BITWIDTH_ERR=4 → ERR_CNT saturates at 15, FIRST_ERR_ADR=0, PASS=0.
- EN toggled low for 5 cycles twice during M3 → total run 670 cycles, PASS=1. No RAM_EN activity while stalled except completing an already-issued read.
- START re-pulsed while BUSY, then RST asserted mid-M2 → the second START has no effect. After reset all outputs are 0 and IDLE is re-entered. A new START then runs a full 660-cycle pass.
- Check the address sequence order: M3 starts at 59 and ends at 0, M5 ends at 59, and ELEM steps 0→5.
